fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
- Parametrised operand-forwarding and hazard-stall controller for the integer pipeline.
- Tracks destination tags of in-flight instructions in an internal shadow pipeline: EX slot plus FWD_DEPTH post-EX stages (stage 1 = MEM, stage 2 = WB, ...).
- Produces per-operand forward selects for the EX stage.
- Detects load-use hazards and holds EX for multi-cycle ops; drives a single `stall` to the fetch/decode control.

Parameters:
- REG_AW, 5, register address width; register 0 is hardwired zero.
- NUM_SRC, 2, source operands per instruction.
- FWD_DEPTH, 2, number of post-EX stages usable as forward sources (>=1).
- MC_LAT, 4, EX occupancy in cycles of a multi-cycle op (>=1).
- SELW (localparam), $clog2(FWD_DEPTH+1), forward-select width.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_wr_en  in  1  ID instruction writes a register.
- id_wr_reg  in  REG_AW  ID destination register.
- id_is_load  in  1  ID instruction is a load.
- id_is_mc  in  1  ID instruction is multi-cycle (mul/div).
- id_src  in  NUM_SRC*REG_AW  ID source registers; operand i at bits [i*REG_AW +: REG_AW].
- flush  in  1  squash ID and EX (branch/exception).
- stall  out  1  hold PC and the IF/ID register this cycle.
- mc_busy  out  1  multi-cycle op occupying EX.
- fwd_sel  out  NUM_SRC*SELW  per EX operand: 0 = regfile value, k = stage k result.

Behaviour:
- Tag entry fields: valid, wr, reg, is_load, is_mc (EX entry also holds the NUM_SRC source registers). Entries live in EX and stages 1..FWD_DEPTH.
- Reset (async): all valid bits 0, mc counter 0. Outputs: stall=0, mc_busy=0, all fwd_sel=0.
- An entry is a write hazard only if valid & wr & reg!=0.
- fwd_sel[i] (combinational from registered state):
  - Value is the smallest k in 1..FWD_DEPTH where stage k is a write hazard with reg == EX src[i]; otherwise 0.
  - A load entry in stage 1 is not eligible; the search continues to deeper stages.
  - Invalid EX entry -> fwd_sel = 0.
- Load-use hazard: EX entry is a load write hazard, id_valid=1, and any id_src equals EX reg.
- mc counter:
  - Loads MC_LAT-1 on the edge an is_mc entry enters EX.
  - Decrements each cycle while nonzero.
  - mc_busy = (counter != 0).
- stall = load_use | mc_busy.
- Per clock edge, in priority order:
  1. flush=1: EX <- invalid, counter <- 0, ID not captured; stages 1..FWD_DEPTH shift normally (stage 1 <- old EX).
  2. mc_busy=1: EX holds, stage 1 <- bubble, deeper stages shift.
  3. load_use=1: EX <- bubble, stage 1 <- old EX, deeper stages shift.
  4. Otherwise: EX <- ID fields (valid = id_valid), stage 1 <- old EX, deeper stages shift.
- The entry in stage FWD_DEPTH falls off each cycle.
- Load-use latency: exactly one stall cycle; the dependent op then sees the load in stage 2.
- MC_LAT=1: no stall and counter never loads.
- A load-use hazard and mc_busy may assert together; stall is still one bit and mc handling takes priority.
- Reset mid-count drops stall and mc_busy immediately (asynchronous).

Optional Feature:
- Macro: FWD_HAZARD_STATS_EN.
- When defined, adds two outputs:
  - stat_stall_cyc  out  32: counts cycles with stall=1.
  - stat_fwd_evt  out  32: counts cycles with any fwd_sel != 0 and a valid EX entry.
- Both counters saturate at 0xFFFFFFFF and are cleared by rst.
- When undefined, neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- ALU dependency: add r3 (wr r3) then sub using r3 as src0, no stalls -> cycle sub is in EX: fwd_sel[0]=1, fwd_sel[1]=0, stall=0.
- Distance and priority:
  - Write r4, one unrelated op, then reader of r4 -> fwd_sel[0]=2.
  - Two consecutive writes of r4 then reader -> fwd_sel[0]=1 (nearest wins).
- Load-use: lw r5 then add src1=r5 -> stall=1 for exactly one cycle while lw in EX; next cycle EX bubble; add enters EX with fwd_sel[1]=2.
- Zero register: wr_en to r0, then reader of r0 -> fwd_sel=0, no stall. A load to r0 followed by a reader of r0 -> no stall.
- Multi-cycle (MC_LAT=4): mc op enters EX -> mc_busy/stall high 3 cycles and stage 1 receives 3 bubbles. Repeat with flush in the 2nd busy cycle -> stall=0 the following cycle and EX invalid.
- Async reset mid-count: assert rst between clock edges with counter=2 -> stall, mc_busy and all fwd_sel = 0 before the next edge. With FWD_HAZARD_STATS_EN, stat_stall_cyc reads 0.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and hazard-stall controller: shadow tag pipeline (EX + FWD_DEPTH stages),
// per-operand forward selects, load-use and multi-cycle stalls. Define FWD_HAZARD_STATS_EN for stat counters.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned NUM_SRC   = 2,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned MC_LAT    = 4,
  localparam int unsigned SELW     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic                      id_wr_en,
  input  logic [REG_AW-1:0]         id_wr_reg,
  input  logic                      id_is_load,
  input  logic                      id_is_mc,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic                      flush,
  output logic                      stall,
  output logic                      mc_busy,
  output logic [NUM_SRC*SELW-1:0]   fwd_sel
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [31:0]               stat_stall_cyc,
  output logic [31:0]               stat_fwd_evt
`endif
);

  localparam int unsigned CNTW = (MC_LAT > 1) ? $clog2(MC_LAT) : 1;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_AW-1:0] rd;
    logic              is_load;
  } tag_t;

  tag_t                      ex_tag;
  logic [NUM_SRC*REG_AW-1:0] ex_src;
  tag_t                      stage [1:FWD_DEPTH];
  logic [CNTW-1:0]           mc_cnt;
  logic                      load_use;
  logic [SELW-1:0]           sel;
  logic [REG_AW-1:0]         cur_src;

  function automatic logic is_wr_hazard(input tag_t t);
    return t.valid && t.wr && (t.rd != '0);
  endfunction

  always_comb begin
    load_use = 1'b0;
    if (is_wr_hazard(ex_tag) && ex_tag.is_load && id_valid) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (id_src[i*REG_AW +: REG_AW] == ex_tag.rd) load_use = 1'b1;
      end
    end
  end

  assign mc_busy = (mc_cnt != '0);
  assign stall   = load_use | mc_busy;

  // Deepest-first scan so the nearest eligible stage overwrites; a load in stage 1 has no data yet.
  always_comb begin
    fwd_sel = '0;
    sel     = '0;
    cur_src = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      sel     = '0;
      cur_src = ex_src[i*REG_AW +: REG_AW];
      for (int unsigned k = FWD_DEPTH; k >= 1; k--) begin
        if (is_wr_hazard(stage[k]) && (stage[k].rd == cur_src) &&
            !((k == 1) && stage[k].is_load)) begin
          sel = SELW'(k);
        end
      end
      if (ex_tag.valid) fwd_sel[i*SELW +: SELW] = sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_tag <= '0;
      ex_src <= '0;
      mc_cnt <= '0;
      for (int unsigned k = 1; k <= FWD_DEPTH; k++) stage[k] <= '0;
    end else begin
      for (int unsigned k = FWD_DEPTH; k >= 2; k--) stage[k] <= stage[k-1];
      if (flush) begin
        stage[1]     <= ex_tag;
        ex_tag.valid <= 1'b0;
        mc_cnt       <= '0;
      end else if (mc_busy) begin
        // EX holds the multi-cycle op; bubbles drain into stage 1 meanwhile.
        stage[1] <= '0;
        mc_cnt   <= mc_cnt - CNTW'(1);
      end else if (load_use) begin
        stage[1]     <= ex_tag;
        ex_tag.valid <= 1'b0;
      end else begin
        stage[1] <= ex_tag;
        ex_tag   <= '{valid: id_valid, wr: id_wr_en, rd: id_wr_reg, is_load: id_is_load};
        ex_src   <= id_src;
        if (id_valid && id_is_mc) mc_cnt <= CNTW'(MC_LAT - 1);
      end
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic fwd_any;
  assign fwd_any = ex_tag.valid && (fwd_sel != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_stall_cyc <= '0;
      stat_fwd_evt   <= '0;
    end else begin
      if (stall && (stat_stall_cyc != '1)) stat_stall_cyc <= stat_stall_cyc + 32'd1;
      if (fwd_any && (stat_fwd_evt != '1)) stat_fwd_evt <= stat_fwd_evt + 32'd1;
    end
  end
`endif

endmodule
